// File: rtl/alu_pkg.sv
// Shared ALU opcodes, operand widths and multiply-sequencer state encoding.
package alu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned CNT_W  = 6;

   localparam logic [OP_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [OP_W-1:0] ALU_SUB = 4'b0001;
   localparam logic [OP_W-1:0] ALU_AND = 4'b0010;
   localparam logic [OP_W-1:0] ALU_OR  = 4'b0011;
   localparam logic [OP_W-1:0] ALU_XOR = 4'b0100;
   localparam logic [OP_W-1:0] ALU_SLL = 4'b0110;
   localparam logic [OP_W-1:0] ALU_SRL = 4'b0111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ITER,
      ST_ADD,
      ST_SHA,
      ST_SHB,
      ST_DONE
   } seq_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [OP_W-1:0]   op;
   } alu_drive_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-and-add multiplier that borrows an external shared ALU for all arithmetic.
// Build option: ALU_MUL_SEQ_EARLY_EXIT_EN stops iterating once the remaining multiplier is zero.
module alu_mul_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned ITER_COUNT = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_out
);

   seq_state_e        state, state_nxt;
   logic [DATA_W-1:0] mcand, mcand_nxt;
   logic [DATA_W-1:0] mplier, mplier_nxt;
   logic [DATA_W-1:0] prod, prod_nxt;
   logic [DATA_W-1:0] result_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   alu_drive_t        drv_nxt;
   logic              terminate;

   always_comb begin
      terminate = (cnt == CNT_W'(ITER_COUNT));
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
      terminate = terminate || (mplier == '0);
`else
      terminate = terminate || 1'b0;
`endif
   end

   // Next state, datapath updates, and the ALU drive for the state being entered.
   always_comb begin
      state_nxt  = state;
      mcand_nxt  = mcand;
      mplier_nxt = mplier;
      prod_nxt   = prod;
      cnt_nxt    = cnt;
      result_nxt = result;
      drv_nxt    = '{a: '0, b: '0, op: ALU_ADD};

      case (state)
         ST_IDLE: begin
            if (start) begin
               mcand_nxt  = op_a;
               mplier_nxt = op_b;
               prod_nxt   = '0;
               cnt_nxt    = '0;
               state_nxt  = ST_ITER;
            end
         end
         ST_ITER: begin
            if (terminate) begin
               result_nxt = prod;
               state_nxt  = ST_DONE;
            end else if (mplier[0]) begin
               state_nxt = ST_ADD;
            end else begin
               state_nxt = ST_SHA;
            end
         end
         ST_ADD: begin
            prod_nxt  = alu_out;
            state_nxt = ST_SHA;
         end
         ST_SHA: begin
            mcand_nxt = alu_out;
            state_nxt = ST_SHB;
         end
         ST_SHB: begin
            mplier_nxt = alu_out;
            cnt_nxt    = cnt + CNT_W'(1);
            state_nxt  = ST_ITER;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase

      // Drives are registered, so they are computed from the values valid in the next state.
      case (state_nxt)
         ST_ADD: drv_nxt = '{a: prod_nxt,   b: mcand_nxt,         op: ALU_ADD};
         ST_SHA: drv_nxt = '{a: mcand_nxt,  b: DATA_W'(1),        op: ALU_SLL};
         ST_SHB: drv_nxt = '{a: mplier_nxt, b: DATA_W'(1),        op: ALU_SRL};
         default: drv_nxt = '{a: '0,        b: '0,                op: ALU_ADD};
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         cnt    <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= ALU_ADD;
      end else begin
         state  <= state_nxt;
         mcand  <= mcand_nxt;
         mplier <= mplier_nxt;
         prod   <= prod_nxt;
         cnt    <= cnt_nxt;
         result <= result_nxt;
         busy   <= (state_nxt != ST_IDLE);
         done   <= (state_nxt == ST_DONE);
         alu_a  <= drv_nxt.a;
         alu_b  <= drv_nxt.b;
         alu_op <= drv_nxt.op;
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: wraps a behavioural ALU, checks against an arithmetic reference.
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   localparam int unsigned ITER = 32;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] op_a, op_b, result, alu_a, alu_b, alu_out;
   logic [3:0]  alu_op;
   logic        busy, done;

   int vectors = 0;
   int fails   = 0;

   always #5 clk = ~clk;

   alu_mul_sequencer #(.ITER_COUNT(ITER)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op_a    (op_a),
      .op_b    (op_b),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_op  (alu_op),
      .alu_out (alu_out)
   );

   // Shared ALU living outside the sequencer
   always_comb begin
      case (alu_op)
         4'b0000: alu_out = alu_a + alu_b;
         4'b0001: alu_out = alu_a - alu_b;
         4'b0110: alu_out = alu_a << alu_b[4:0];
         4'b0111: alu_out = alu_a >> alu_b[4:0];
         default: alu_out = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int exp_latency(input logic [31:0] b);
      int pop = 0;
      int top = 0;
      for (int i = 0; i < int'(ITER); i++) begin
         if (b[i]) begin
            pop++;
            top = i + 1;
         end
      end
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
      return 2 + 3 * top + pop;
`else
      return 2 + 3 * int'(ITER) + pop;
`endif
   endfunction

   function automatic logic [31:0] exp_product(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      return p[31:0];
   endfunction

   task automatic chk_alu(input int cyc);
      logic legal;
      legal = (alu_op == 4'b0000) || (alu_op == 4'b0110) || (alu_op == 4'b0111);
      chk($sformatf("alu_op_legal c%0d", cyc), 32'(legal), 32'd1);
      if (alu_op == 4'b0110 || alu_op == 4'b0111)
         chk($sformatf("shift_b_one c%0d", cyc), alu_b, 32'd1);
   endtask

   // Caller sits at a falling edge; returns at the falling edge of the first idle cycle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input int stray1, input int stray2, input string name);
      int          lat;
      logic [31:0] res;
      lat   = exp_latency(b);
      res   = exp_product(a, b);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      @(posedge clk);
      for (int cyc = 1; cyc <= lat; cyc++) begin
         @(negedge clk);
         chk($sformatf("%s busy c%0d", name, cyc), 32'(busy), 32'd1);
         chk($sformatf("%s done c%0d", name, cyc), 32'(done), 32'(cyc == lat));
         if (cyc == lat) chk($sformatf("%s result", name), result, res);
         chk_alu(cyc);
         start = (cyc == stray1) || (cyc == stray2);
         op_a  = $urandom;
         op_b  = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("%s idle busy", name), 32'(busy), 32'd0);
      chk($sformatf("%s idle done", name), 32'(done), 32'd0);
      chk($sformatf("%s held result", name), result, res);
   endtask

   initial begin
      int abort_cyc;
      logic [31:0] ra, rb;

      reset_n = 1'b0;
      start   = 1'b0;
      op_a    = '0;
      op_b    = '0;
      repeat (2) @(negedge clk);
      chk("rst busy",   32'(busy),   32'd0);
      chk("rst done",   32'(done),   32'd0);
      chk("rst result", result,      32'd0);
      chk("rst alu_a",  alu_a,       32'd0);
      chk("rst alu_b",  alu_b,       32'd0);
      chk("rst alu_op", 32'(alu_op), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      run_op(32'd7, 32'd6, -1, -1, "m7x6");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, "mFxF");
      run_op(32'd5, 32'd0, -1, -1, "m5x0");
      run_op(32'd9, 32'd1, -1, -1, "m9x1");
      // Stray starts during the op and in its done cycle; next start lands right after
      run_op(32'd7, 32'd6, 5, exp_latency(32'd6), "stray7x6");
      run_op(32'd11, 32'd13, -1, -1, "back2back");

      // Reset mid-operation
      abort_cyc = (exp_latency(32'd4) > 41) ? 40 : exp_latency(32'd4) - 2;
      start = 1'b1;
      op_a  = 32'd3;
      op_b  = 32'd4;
      @(posedge clk);
      for (int cyc = 1; cyc < abort_cyc; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("abort busy c%0d", cyc), 32'(busy), 32'd1);
         chk($sformatf("abort done c%0d", cyc), 32'(done), 32'd0);
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort busy now",   32'(busy),   32'd0);
      chk("abort done now",   32'(done),   32'd0);
      chk("abort result now", result,      32'd0);
      chk("abort alu_a",      alu_a,       32'd0);
      chk("abort alu_b",      alu_b,       32'd0);
      chk("abort alu_op",     32'(alu_op), 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("abort hold done", 32'(done), 32'd0);
         chk("abort hold busy", 32'(busy), 32'd0);
      end
      reset_n = 1'b1;
      run_op(32'd3, 32'd4, -1, -1, "m3x4");

      for (int n = 0; n < 16; n++) begin
         ra = $urandom;
         case (n % 4)
            0: rb = $urandom;
            1: rb = 32'($urandom_range(0, 255));
            2: rb = 32'(1) << $urandom_range(0, 31);
            default: rb = $urandom & $urandom;
         endcase
         run_op(ra, rb, int'($urandom_range(1, 60)), -1, $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
